// File: rtl/gpr_file_sb.sv
// gpr_file_sb: NUM_REGS x DATA_W register file, two registered read ports,
// one write port with same-cycle bypass, a multiply-high register and a
// pending-write scoreboard.
// Ports: clk/rst (async, active-high); rd_en/rs_a/rs_b -> rd_a_data,
// rd_b_data, rd_valid; wr_en/wr_addr/wr_data; hi_wr_en/hi_wr_data -> hi_out;
// rsv_en/rsv_addr; busy_a/busy_b = pending[rs_a]/pending[rs_b].
// Option: define GPR_ZERO_REG_EN to hardwire GPR[0] to zero.
module gpr_file_sb #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hi_wr_en,
  input  logic [DATA_W-1:0] hi_wr_data,
  output logic [DATA_W-1:0] hi_out,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pendNext;
  logic                wrOk;
  logic                rsvOk;
  logic [DATA_W-1:0]   nextA;
  logic [DATA_W-1:0]   nextB;

`ifdef GPR_ZERO_REG_EN
  assign wrOk  = wr_en && (wr_addr != '0);
  assign rsvOk = rsv_en && (rsv_addr != '0);
`else
  assign wrOk  = wr_en;
  assign rsvOk = rsv_en;
`endif

  // Read muxes with write bypass so a same-cycle write is never stale.
  always_comb begin
    nextA = regs[rs_a];
    nextB = regs[rs_b];
    if (wrOk && (rs_a == wr_addr)) nextA = wr_data;
    if (wrOk && (rs_b == wr_addr)) nextB = wr_data;
`ifdef GPR_ZERO_REG_EN
    if (rs_a == '0) nextA = '0;
    if (rs_b == '0) nextB = '0;
`endif
  end

  // A new reservation wins over a completing write to the same index.
  always_comb begin
    pendNext = pending;
    if (wrOk) pendNext[wr_addr] = 1'b0;
    if (rsvOk) pendNext[rsv_addr] = 1'b1;
  end

  // Busy reflects state before the edge; clears are not forwarded.
  assign busy_a = pending[rs_a];
  assign busy_b = pending[rs_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wrOk) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_a_data <= nextA;
        rd_b_data <= nextB;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_out <= '0;
    end else if (hi_wr_en) begin
      hi_out <= hi_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pendNext;
    end
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed test-plan steps followed by random traffic,
// checked against an array-based reference model of the register file.
module tb_gpr_file_sb;

`ifdef GPR_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic [2:0] rs_a = '0;
  logic [2:0] rs_b = '0;
  logic [7:0] rd_a_data;
  logic [7:0] rd_b_data;
  logic       rd_valid;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       hi_wr_en = 1'b0;
  logic [7:0] hi_wr_data = '0;
  logic [7:0] hi_out;
  logic       rsv_en = 1'b0;
  logic [2:0] rsv_addr = '0;
  logic       busy_a;
  logic       busy_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] mGpr [8];
  bit         mPend [8];
  logic [7:0] mHi;
  logic [7:0] expA;
  logic [7:0] expB;
  bit         expV;

  gpr_file_sb dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rs_a(rs_a), .rs_b(rs_b),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hi_wr_en(hi_wr_en), .hi_wr_data(hi_wr_data),
    .hi_out(hi_out),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mGpr[i] = 8'h00;
      mPend[i] = 1'b0;
    end
    mHi = 8'h00;
    expA = 8'h00;
    expB = 8'h00;
    expV = 1'b0;
  endtask

  function automatic logic [7:0] readRef(logic [2:0] idx, bit we,
                                         logic [2:0] wa, logic [7:0] wd);
    if (ZR && idx == 3'd0) return 8'h00;
    if (we && !(ZR && wa == 3'd0) && idx == wa) return wd;
    return mGpr[idx];
  endfunction

  // One clock cycle: drive, check busy before the edge, then outputs after.
  task automatic cyc(bit re, logic [2:0] a, logic [2:0] b,
                     bit we, logic [2:0] wa, logic [7:0] wd,
                     bit he, logic [7:0] hd, bit rv, logic [2:0] ra);
    rd_en = re; rs_a = a; rs_b = b;
    wr_en = we; wr_addr = wa; wr_data = wd;
    hi_wr_en = he; hi_wr_data = hd;
    rsv_en = rv; rsv_addr = ra;
    #1;
    check("busy_a", {7'd0, busy_a}, {7'd0, mPend[a]});
    check("busy_b", {7'd0, busy_b}, {7'd0, mPend[b]});
    if (re) begin
      expA = readRef(a, we, wa, wd);
      expB = readRef(b, we, wa, wd);
    end
    expV = re;
    if (we && !(ZR && wa == 3'd0)) begin
      mGpr[wa] = wd;
      mPend[wa] = 1'b0;
    end
    if (rv && !(ZR && ra == 3'd0)) mPend[ra] = 1'b1;
    if (he) mHi = hd;
    @(posedge clk);
    #1;
    check("rd_valid", {7'd0, rd_valid}, {7'd0, expV});
    check("rd_a_data", rd_a_data, expA);
    check("rd_b_data", rd_b_data, expB);
    check("hi_out", hi_out, mHi);
  endtask

  initial begin
    modelReset();
    #2;
    check("rst_rd_a", rd_a_data, 8'h00);
    check("rst_valid", {7'd0, rd_valid}, 8'h00);
    check("rst_hi", hi_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic write/read
    cyc(0, 0, 0, 1, 2, 8'hA5, 0, 0, 0, 0);
    cyc(1, 2, 7, 0, 0, 0, 0, 0, 0, 0);
    check("basic_a", rd_a_data, 8'hA5);
    check("basic_b", rd_b_data, 8'h00);
    cyc(0, 2, 7, 0, 0, 0, 0, 0, 0, 0);
    check("basic_hold", rd_a_data, 8'hA5);

    // Bypass on both ports
    cyc(0, 0, 0, 1, 5, 8'h11, 0, 0, 0, 0);
    cyc(1, 5, 5, 1, 5, 8'h22, 0, 0, 0, 0);
    check("byp_a", rd_a_data, 8'h22);
    check("byp_b", rd_b_data, 8'h22);
    cyc(1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
    check("byp_stored", rd_a_data, 8'h22);

    // Scoreboard: set wins over concurrent write
    cyc(0, 4, 4, 0, 0, 0, 0, 0, 1, 4);
    cyc(0, 4, 4, 1, 4, 8'h33, 0, 0, 1, 4);
    check("sb_set_wins", {7'd0, busy_a}, 8'h01);
    cyc(0, 4, 4, 1, 4, 8'h44, 0, 0, 0, 0);
    check("sb_cleared", {7'd0, busy_a}, 8'h00);

    // Multiply-high alongside a GPR write
    cyc(0, 0, 0, 1, 1, 8'h0F, 1, 8'hF0, 0, 0);
    check("hi_indep", hi_out, 8'hF0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("gpr1", rd_a_data, 8'h0F);

    // Index 0 behaviour (hardwired zero only with the option)
    cyc(1, 0, 0, 1, 0, 8'hFF, 0, 0, 1, 0);
    check("zero_rd", rd_a_data, ZR ? 8'h00 : 8'hFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("zero_busy", {7'd0, busy_a}, ZR ? 8'h00 : 8'h01);
    cyc(0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 1), 3'($urandom), 3'($urandom),
          $urandom_range(0, 1), 3'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0), 8'($urandom),
          ($urandom_range(0, 2) == 0), 3'($urandom));
    end

    // Reset mid-operation
    cyc(0, 0, 0, 1, 3, 8'h5A, 1, 8'h77, 0, 0);
    cyc(1, 3, 3, 0, 0, 0, 0, 0, 1, 3);
    check("pre_rst_a", rd_a_data, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    check("mid_rst_a", rd_a_data, 8'h00);
    check("mid_rst_valid", {7'd0, rd_valid}, 8'h00);
    check("mid_rst_hi", hi_out, 8'h00);
    check("mid_rst_busy", {7'd0, busy_a}, 8'h00);
    rd_en = 1'b0;
    rsv_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_rd3", rd_a_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised successor to the 8x8 general-purpose register file.
- Two read ports with registered outputs, one write port, and a separately writable multiply-high register.
- Reads and writes may occur in the same cycle. Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard so the control FSM can detect RAW hazards before issuing.
- Sits between the decode/control FSM and the ALU/multiplier writeback path.

Parameters:
- DATA_W, 8: register width in bits.
- NUM_REGS, 8: number of GPRs. Power of two, 2..32.
- ADDR_W, $clog2(NUM_REGS): register index width. Derived; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  capture both read ports this cycle.
- rs_a  in  ADDR_W  read index, port A.
- rs_b  in  ADDR_W  read index, port B.
- rd_a_data  out  DATA_W  registered read data, port A.
- rd_b_data  out  DATA_W  registered read data, port B.
- rd_valid  out  1  high the cycle after an accepted rd_en.
- wr_en  in  1  write GPR[wr_addr].
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write data.
- hi_wr_en  in  1  write multiply-high register.
- hi_wr_data  in  DATA_W  multiply-high write data.
- hi_out  out  DATA_W  current multiply-high register value.
- rsv_en  in  1  reserve (mark pending) GPR[rsv_addr].
- rsv_addr  in  ADDR_W  index to reserve.
- busy_a  out  1  pending[rs_a]. Combinational from the scoreboard.
- busy_b  out  1  pending[rs_b]. Combinational from the scoreboard.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. On rst, all GPRs, the multiply-high register, rd_a_data, rd_b_data, hi_out and all pending bits clear to 0, and rd_valid goes 0. Assertion takes effect immediately, without a clock edge. An in-flight read or write in the reset cycle is discarded.
- Read latency is 1 cycle:
  - rd_en sampled high at edge N → rd_a_data/rd_b_data hold GPR[rs_a]/GPR[rs_b] after edge N, and rd_valid = 1 for that one cycle.
  - With rd_en low, the data outputs hold their last value and rd_valid = 0.
- Write: wr_en at edge N updates GPR[wr_addr] at edge N. Read and write are independent; a write is never blocked by rd_en, unlike the previous generation, which gave read priority.
- Bypass: if rd_en and wr_en are both high and rs_a == wr_addr (or rs_b == wr_addr), that read port returns wr_data, not the stale value. Both ports bypass if both match.
- Multiply-high:
  - hi_wr_en updates the register at the edge. It is independent of wr_en; both may fire in one cycle.
  - hi_out is the register itself, with no bypass.
- Scoreboard, pending[NUM_REGS-1:0]:
  - rsv_en sets pending[rsv_addr] at the edge.
  - wr_en clears pending[wr_addr] at the edge.
  - If rsv_en and wr_en target the same index in one cycle, set wins: the new reservation supersedes the completing write.
  - Reserving an already-pending register leaves it pending, with no error.
  - A write to a non-pending register is legal and leaves the bit 0.
- busy_a/busy_b reflect pending state before the current edge. A same-cycle clear by wr_en is not forwarded; the control FSM relies on the bypass path instead.
- Arithmetic: none. All values are stored and returned unmodified at DATA_W bits.

Optional Feature:
- Macro: GPR_ZERO_REG_EN.
- Defined:
  - GPR[0] is hardwired to zero. Writes to index 0 are dropped.
  - Reads of index 0 return 0, including on a same-cycle bypass.
  - rsv_en to index 0 is ignored, so pending[0] is always 0 and busy on index 0 is always 0.
- Undefined: index 0 is an ordinary register.

Test Plan:
- Reset mid-operation:
  - Stimulus: write GPR[3]=0x5A, reserve GPR[3], then assert rst between edges.
  - Response: immediately rd_a_data=0, rd_valid=0, hi_out=0 and busy for index 3 = 0. A subsequent read of index 3 returns 0x00.
- Basic write/read:
  - Stimulus: write GPR[2]=0xA5 at edge 1; rd_en with rs_a=2, rs_b=7 at edge 2.
  - Response: after edge 2, rd_a_data=0xA5, rd_b_data=0x00, rd_valid=1. After edge 3 with rd_en low, rd_valid=0 and the data is held.
- Bypass:
  - Stimulus: GPR[5]=0x11; at one edge, wr_en with wr_addr=5, wr_data=0x22, plus rd_en with rs_a=5, rs_b=5.
  - Response: both ports read 0x22; GPR[5]=0x22 afterward.
- Scoreboard:
  - Stimulus: rsv_en for index 4; then rs_a=4, giving busy_a=1. Then wr_en to index 4 concurrent with rsv_en to index 4. Then wr_en alone to index 4.
  - Response: busy_a stays 1 after the concurrent cycle. After the lone write, busy_a=0.
- Multiply-high independence:
  - Stimulus: in one cycle, wr_en with wr_addr=1, wr_data=0x0F and hi_wr_en with hi_wr_data=0xF0.
  - Response: GPR[1]=0x0F and hi_out=0xF0 after the edge.
- GPR_ZERO_REG_EN:
  - Stimulus: macro defined; write index 0 with 0xFF concurrent with a read of index 0; also rsv_en for index 0.
  - Response: read returns 0x00 and busy for index 0 stays 0. With the macro undefined, the read returns 0xFF.
